// File: rtl/cart_mapper.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | cart_mapper                                                              |
// | F8/F6/F4 cartridge bank-switching mapper with optional 128-byte          |
// | Superchip RAM, compiled in when CART_SUPERCHIP_EN is defined.            |
// | Revision: 1.0                                                            |
// +--------------------------------------------------------------------------+
module cart_mapper #(
    parameter int BANKS = 2,
    parameter int BW    = $clog2(BANKS)
) (
    input  logic           MCLK,
    input  logic           RES,
    input  logic           CS,
    input  logic [11:0]    ADDR,
    input  logic           R_W,
    input  logic [7:0]     D_WR,
    input  logic [7:0]     ROM_Q,
    output logic [11+BW:0] ROM_ADDR,
    output logic [7:0]     D_OUT,
    output logic [BW-1:0]  BANK
);

    // Standard hotspot windows: F8 0xFF8-0xFF9, F6 0xFF6-0xFF9, F4 0xFF4-0xFFB.
    localparam logic [11:0]   c_hot_base   = (BANKS == 8) ? 12'hFF4 :
                                             (BANKS == 4) ? 12'hFF6 : 12'hFF8;
    localparam logic [11:0]   c_hot_count  = 12'(BANKS);
    localparam logic [BW-1:0] c_reset_bank = BW'(BANKS - 1);

    logic [BW-1:0] r_bank;
    logic [11:0]   w_hot_off;
    logic          w_hot;

    // Addresses below the base wrap to large offsets, so one compare covers both ends.
    assign w_hot_off = ADDR - c_hot_base;
    assign w_hot     = CS && (w_hot_off < c_hot_count);

    always_ff @(posedge MCLK or posedge RES) begin
        if (RES) begin
            r_bank <= c_reset_bank;
        end else if (w_hot) begin
            r_bank <= w_hot_off[BW-1:0];
        end
    end

    assign ROM_ADDR = {r_bank, ADDR};
    assign BANK     = r_bank;

`ifdef CART_SUPERCHIP_EN
    logic [7:0] r_ram [0:127];
    logic       w_ram_we;
    logic       w_ram_rd;
    logic       w_wport_rd;

    assign w_ram_we   = CS && !R_W && (ADDR[11:7] == 5'd0);
    assign w_ram_rd   = CS && (ADDR[11:7] == 5'd1);
    assign w_wport_rd = CS && R_W && (ADDR[11:7] == 5'd0);

    // No reset: contents survive RES by design.
    always_ff @(posedge MCLK) begin
        if (w_ram_we) begin
            r_ram[ADDR[6:0]] <= D_WR;
        end
    end

    always_comb begin
        D_OUT = ROM_Q;
        if (w_ram_rd) begin
            D_OUT = r_ram[ADDR[6:0]];
        end else if (w_wport_rd) begin
            D_OUT = 8'hFF;
        end
    end
`else
    logic w_unused_ok;
    assign w_unused_ok = ^{R_W, D_WR};
    assign D_OUT       = ROM_Q;
`endif

endmodule
`default_nettype wire

// File: tb/tb_cart_mapper.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | tb_cart_mapper                                                           |
// | Scoreboard bench driving F8, F6 and F4 mapper instances in lockstep.     |
// | Revision: 1.0                                                            |
// +--------------------------------------------------------------------------+
module tb_cart_mapper;

`ifdef CART_SUPERCHIP_EN
    localparam bit SUPERCHIP = 1'b1;
`else
    localparam bit SUPERCHIP = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        cs = 1'b0;
    logic [11:0] addr = 12'h000;
    logic        r_w = 1'b1;
    logic [7:0]  d_wr = 8'h00;
    logic [7:0]  rom_q = 8'h00;

    logic [12:0] ra2;
    logic [13:0] ra4;
    logic [14:0] ra8;
    logic [0:0]  bank2;
    logic [1:0]  bank4;
    logic [2:0]  bank8;
    logic [7:0]  dout2, dout4, dout8;
    logic [71:0] obs;

    int passes = 0;
    int checks = 0;
    logic [71:0] exp;
    logic [71:0] sb[$];

    logic [2:0] m_bank [3];
    logic [7:0] m_ram [128];

    always #5 clk = ~clk;

    cart_mapper #(.BANKS(2)) u_f8 (
        .MCLK(clk), .RES(rst), .CS(cs), .ADDR(addr), .R_W(r_w), .D_WR(d_wr),
        .ROM_Q(rom_q), .ROM_ADDR(ra2), .D_OUT(dout2), .BANK(bank2)
    );
    cart_mapper #(.BANKS(4)) u_f6 (
        .MCLK(clk), .RES(rst), .CS(cs), .ADDR(addr), .R_W(r_w), .D_WR(d_wr),
        .ROM_Q(rom_q), .ROM_ADDR(ra4), .D_OUT(dout4), .BANK(bank4)
    );
    cart_mapper #(.BANKS(8)) u_f4 (
        .MCLK(clk), .RES(rst), .CS(cs), .ADDR(addr), .R_W(r_w), .D_WR(d_wr),
        .ROM_Q(rom_q), .ROM_ADDR(ra8), .D_OUT(dout8), .BANK(bank8)
    );

    assign obs = {ra2, ra4, ra8, bank2, bank4, bank8, dout2, dout4, dout8};

    function automatic int hot_base(input int n);
        case (n)
            2:       return 'hFF8;
            4:       return 'hFF6;
            default: return 'hFF4;
        endcase
    endfunction

    // Reference model: instance k has 2<<k banks.
    always @(posedge clk or posedge rst) begin
        if (rst) begin
            m_bank[0] <= 3'd1;
            m_bank[1] <= 3'd3;
            m_bank[2] <= 3'd7;
        end else begin
            for (int k = 0; k < 3; k++) begin
                if (cs && int'(addr) >= hot_base(2 << k) &&
                    int'(addr) < hot_base(2 << k) + (2 << k))
                    m_bank[k] <= 3'(int'(addr) - hot_base(2 << k));
            end
        end
    end

    always @(posedge clk) begin
        if (SUPERCHIP && cs && !r_w && addr[11:7] == 5'd0)
            m_ram[addr[6:0]] <= d_wr;
    end

    function automatic logic [71:0] expect_now();
        logic [7:0] d;
        d = rom_q;
        if (SUPERCHIP && cs && addr[11:7] == 5'd1)
            d = m_ram[addr[6:0]];
        else if (SUPERCHIP && cs && r_w && addr[11:7] == 5'd0)
            d = 8'hFF;
        return {m_bank[0][0], addr, m_bank[1][1:0], addr, m_bank[2], addr,
                m_bank[0][0], m_bank[1][1:0], m_bank[2], d, d, d};
    endfunction

    task automatic drive(input logic c, input logic [11:0] a, input logic rw,
                         input logic [7:0] wd, input logic [7:0] q);
        cs = c; addr = a; r_w = rw; d_wr = wd; rom_q = q;
        #1;
        sb.push_back(expect_now());
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        drive(1'b0, 12'hFFC, 1'b1, 8'h00, 8'h12);
        @(negedge clk); exp = sb.pop_front(); checks++;
        if (obs !== exp) $display("FAIL reset_sb: got %h want %h", obs, exp); else passes++;
        checks++;
        if (bank2 !== 1'b1) $display("FAIL reset_bank2: got %h want 1", bank2); else passes++;
        checks++;
        if (ra2 !== 13'h1FFC) $display("FAIL reset_romaddr2: got %h want 1ffc", ra2); else passes++;
        checks++;
        if (bank4 !== 2'd3 || bank8 !== 3'd7)
            $display("FAIL reset_bank48: got %h/%h want 3/7", bank4, bank8);
        else passes++;
        tick();
        rst = 1'b0;
    endtask

    task automatic test_f8_switch();
        drive(1'b1, 12'hFF8, 1'b1, 8'h00, 8'h34);
        @(negedge clk); exp = sb.pop_front(); checks++;
        if (obs !== exp) $display("FAIL f8_hot_sb: got %h want %h", obs, exp); else passes++;
        checks++;
        if (ra2 !== 13'h1FF8) $display("FAIL f8_old_bank: got %h want 1ff8", ra2); else passes++;
        tick();
        drive(1'b0, 12'hFF8, 1'b1, 8'h00, 8'h56);
        @(negedge clk); exp = sb.pop_front(); checks++;
        if (obs !== exp) $display("FAIL f8_after_sb: got %h want %h", obs, exp); else passes++;
        checks++;
        if (bank2 !== 1'b0 || ra2 !== 13'h0FF8)
            $display("FAIL f8_new_bank: got %h/%h want 0/0ff8", bank2, ra2);
        else passes++;
        tick();
        drive(1'b1, 12'hFF9, 1'b0, 8'h00, 8'h78);
        @(negedge clk); exp = sb.pop_front(); checks++;
        if (obs !== exp) $display("FAIL f8_wr_sb: got %h want %h", obs, exp); else passes++;
        tick();
        drive(1'b0, 12'h000, 1'b1, 8'h00, 8'h9A);
        @(negedge clk); exp = sb.pop_front(); checks++;
        if (obs !== exp) $display("FAIL f8_wr_after_sb: got %h want %h", obs, exp); else passes++;
        checks++;
        if (bank2 !== 1'b1) $display("FAIL f8_write_switch: got %h want 1", bank2); else passes++;
        tick();
    endtask

    task automatic test_cs_gating();
        logic [11:0] a_tab [3] = '{12'hFF6, 12'hFFB, 12'hFF4};
        logic        c_tab [3] = '{1'b0, 1'b1, 1'b1};
        for (int i = 0; i < 3; i++) begin
            drive(c_tab[i], a_tab[i], 1'b1, 8'h00, 8'(i + 8'h40));
            @(negedge clk); exp = sb.pop_front(); checks++;
            if (obs !== exp) $display("FAIL cs_hot_sb%0d: got %h want %h", i, obs, exp); else passes++;
            tick();
            drive(1'b0, 12'h200, 1'b1, 8'h00, 8'(i + 8'h50));
            @(negedge clk); exp = sb.pop_front(); checks++;
            if (obs !== exp) $display("FAIL cs_after_sb%0d: got %h want %h", i, obs, exp); else passes++;
            tick();
        end
        // Banks after the sequence: F6 held at 3, F4 went 7 then 0.
        checks++;
        if (bank4 !== 2'd3) $display("FAIL cs_gate_f6: got %h want 3", bank4); else passes++;
        checks++;
        if (bank8 !== 3'd0) $display("FAIL cs_f4_ff4: got %h want 0", bank8); else passes++;
    endtask

    task automatic test_sweep();
        logic [11:0] a;
        for (int i = 0; i < 40; i++) begin
            if ($urandom_range(0, 3) != 0)
                a = 12'hFF0 + 12'($urandom_range(0, 15));
            else
                a = 12'h100 + 12'($urandom_range(0, 'hEEF));
            drive(1'($urandom_range(0, 1)), a, 1'($urandom_range(0, 1)),
                  8'($urandom), 8'($urandom));
            @(negedge clk); exp = sb.pop_front(); checks++;
            if (obs !== exp) $display("FAIL sweep%0d: got %h want %h", i, obs, exp); else passes++;
            tick();
        end
    endtask

`ifdef CART_SUPERCHIP_EN
    task automatic test_superchip();
        logic [11:0] a_tab [7] = '{12'h005, 12'h085, 12'h005, 12'h085, 12'h085, 12'h006, 12'h086};
        logic        w_tab [7] = '{1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1};
        logic [7:0]  d_tab [7] = '{8'hA5, 8'h00, 8'h00, 8'h3C, 8'h00, 8'h11, 8'h00};
        for (int i = 0; i < 7; i++) begin
            drive(1'b1, a_tab[i], w_tab[i], d_tab[i], 8'h5A);
            @(negedge clk); exp = sb.pop_front(); checks++;
            if (obs !== exp) $display("FAIL sc_sb%0d: got %h want %h", i, obs, exp); else passes++;
            if (i == 1 || i == 4) begin
                checks++;
                if (dout2 !== 8'hA5) $display("FAIL sc_read%0d: got %h want a5", i, dout2); else passes++;
            end
            if (i == 2) begin
                checks++;
                if (dout2 !== 8'hFF) $display("FAIL sc_wport_read: got %h want ff", dout2); else passes++;
            end
            if (i == 6) begin
                checks++;
                if (dout2 !== 8'h11) $display("FAIL sc_read6: got %h want 11", dout2); else passes++;
            end
            tick();
        end
    endtask
`else
    task automatic test_no_superchip();
        logic [11:0] a_tab [3] = '{12'h085, 12'h005, 12'h085};
        logic        w_tab [3] = '{1'b1, 1'b0, 1'b1};
        logic [7:0]  q_tab [3] = '{8'h5A, 8'hC3, 8'h5A};
        for (int i = 0; i < 3; i++) begin
            drive(1'b1, a_tab[i], w_tab[i], 8'hA5, q_tab[i]);
            @(negedge clk); exp = sb.pop_front(); checks++;
            if (obs !== exp) $display("FAIL nosc_sb%0d: got %h want %h", i, obs, exp); else passes++;
            checks++;
            if (dout2 !== q_tab[i]) $display("FAIL nosc_dout%0d: got %h want %h", i, dout2, q_tab[i]); else passes++;
            tick();
        end
    endtask
`endif

    task automatic test_reset_mid();
        drive(1'b1, 12'hFF7, 1'b1, 8'h00, 8'h21);
        @(negedge clk); exp = sb.pop_front(); checks++;
        if (obs !== exp) $display("FAIL rm_hot_sb: got %h want %h", obs, exp); else passes++;
        tick();
        drive(1'b0, 12'hFF7, 1'b1, 8'h00, 8'h22);
        @(negedge clk); exp = sb.pop_front(); checks++;
        if (obs !== exp) $display("FAIL rm_pre_sb: got %h want %h", obs, exp); else passes++;
        checks++;
        if (bank4 !== 2'd1) $display("FAIL rm_f6_bank1: got %h want 1", bank4); else passes++;
        #1;
        rst = 1'b1;
        #1;
        sb.push_back(expect_now());
        exp = sb.pop_front(); checks++;
        if (obs !== exp) $display("FAIL rm_async_sb: got %h want %h", obs, exp); else passes++;
        checks++;
        if (bank4 !== 2'd3 || ra4 !== 14'h3FF7)
            $display("FAIL rm_async_f6: got %h/%h want 3/3ff7", bank4, ra4);
        else passes++;
        tick();
        rst = 1'b0;
        drive(1'b1, 12'hFF6, 1'b1, 8'h00, 8'h23);
        @(negedge clk); exp = sb.pop_front(); checks++;
        if (obs !== exp) $display("FAIL rm_release_sb: got %h want %h", obs, exp); else passes++;
        tick();
        drive(1'b1, 12'h085, 1'b1, 8'h00, 8'h24);
        @(negedge clk); exp = sb.pop_front(); checks++;
        if (obs !== exp) $display("FAIL rm_ram_sb: got %h want %h", obs, exp); else passes++;
        checks++;
        if (bank4 !== 2'd0) $display("FAIL rm_release_switch: got %h want 0", bank4); else passes++;
        checks++;
        if (dout2 !== (SUPERCHIP ? 8'hA5 : 8'h24))
            $display("FAIL rm_ram_kept: got %h want %h", dout2, SUPERCHIP ? 8'hA5 : 8'h24);
        else passes++;
        tick();
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        #1;
        test_reset();
        test_f8_switch();
        test_cs_gating();
        test_sweep();
`ifdef CART_SUPERCHIP_EN
        test_superchip();
`else
        test_no_superchip();
`endif
        test_reset_mid();
        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule
`default_nettype wire
